// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arithmetic ops and an
// iterative shift-add multiplier returning the full double-width product.
// Results and zero/carry/negative flags are registered and change only
// together with the one-cycle done pulse.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             z_flag,
    output logic             c_flag,
    output logic             n_flag
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_PASA = 3'b011;
    localparam logic [2:0] OP_PASB = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    // Counter only has to reach WIDTH-1; keep it at least one bit wide.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               z_q, z_d;
    logic               c_q, c_d;
    logic               n_q, n_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] acc_add;
    logic [WIDTH-1:0]   res_w;
    logic               carry_w;

    // Extra top bit of the (WIDTH+1)-bit add/sub is the carry / borrow.
    assign sum_w   = {1'b0, B} + {1'b0, A};
    assign diff_w  = {1'b0, B} - {1'b0, A};
    // The multiplicand register is pre-shifted by the iteration count.
    assign acc_add = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle opcode result and carry from the live operands.
    always_comb begin
        res_w   = '0;
        carry_w = 1'b0;
        case (select)
            OP_ADD: begin
                res_w   = sum_w[WIDTH-1:0];
                carry_w = sum_w[WIDTH];
            end
            OP_SUB: begin
                res_w   = diff_w[WIDTH-1:0];
                carry_w = diff_w[WIDTH];
            end
            OP_PASA: res_w = A;
            OP_PASB: res_w = B;
            OP_AND:  res_w = A & B;
            OP_OR:   res_w = A | B;
            OP_XOR:  res_w = A ^ B;
            default: res_w = '0;
        endcase
    end

    // Next-state, multiply iteration and result/flag update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        out_d    = out_q;
        hi_d     = hi_q;
        z_d      = z_q;
        c_d      = c_q;
        n_d      = n_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (select == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        out_d  = res_w;
                        hi_d   = '0;
                        z_d    = (res_w == '0);
                        c_d    = carry_w;
                        n_d    = res_w[WIDTH-1];
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_add;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_IT) begin
                    out_d   = acc_add[WIDTH-1:0];
                    hi_d    = acc_add[2*WIDTH-1:WIDTH];
                    z_d     = (acc_add[WIDTH-1:0] == '0);
                    c_d     = (acc_add[2*WIDTH-1:WIDTH] != '0);
                    n_d     = acc_add[WIDTH-1];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control, result and flag registers; reset clears all visible state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            z_q     <= z_d;
            c_q     <= c_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end

    // Multiply operand/accumulator registers; reloaded on every MUL start.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
    end

    assign busy   = (state_q == S_MUL);
    assign done   = done_q;
    assign out    = out_q;
    assign out_hi = hi_q;
    assign z_flag = z_q;
    assign c_flag = c_q;
    assign n_flag = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=16): a cycle-level reference model checked
// every cycle, plus directed scenarios with hand-computed expected values.
module tb_alu_seq;

    localparam int W = 16;
    localparam longint MASK = (64'sd1 <<< W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [2:0]    select;
    logic          busy;
    logic          done;
    logic [W-1:0]  out;
    logic [W-1:0]  out_hi;
    logic          z_flag;
    logic          c_flag;
    logic          n_flag;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .select (select),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .out_hi (out_hi),
        .z_flag (z_flag),
        .c_flag (c_flag),
        .n_flag (n_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference result of one operation, from plain unsigned arithmetic.
    function automatic void ref_op(input logic [2:0] sel, input longint a, input longint b,
                                   output longint res, output longint hi, output bit c);
        longint t;
        res = 0; hi = 0; c = 0;
        case (sel)
            3'd0: begin t = a + b; res = t & MASK; c = (t > MASK); end
            3'd1: begin res = (b - a) & MASK; c = (b < a); end
            3'd2: begin t = a * b; res = t & MASK; hi = (t >>> W) & MASK; c = (hi != 0); end
            3'd3: res = a;
            3'd4: res = b;
            3'd5: res = a & b;
            3'd6: res = a | b;
            default: res = a ^ b;
        endcase
    endfunction

    // Model state: expected outputs for the current cycle.
    longint m_out = 0, m_hi = 0;
    bit     m_z = 0, m_c = 0, m_n = 0, m_busy = 0, m_done = 0, m_valid = 0;
    int     m_left = 0;
    longint p_out = 0, p_hi = 0;
    bit     p_c = 0;

    // Model update at each rising edge from the inputs the DUT samples.
    initial begin
        longint r, h;
        bit     cc;
        forever begin
            @(posedge clk);
            cyc++;
            m_valid = 1;
            m_done  = 0;
            if (rst) begin
                m_out = 0; m_hi = 0; m_z = 0; m_c = 0; m_n = 0;
                m_busy = 0; m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_out = p_out; m_hi = p_hi; m_c = p_c;
                    m_z = (p_out == 0); m_n = p_out[W-1];
                end else begin
                    m_busy = 1;
                end
            end else begin
                m_busy = 0;
                if (start) begin
                    ref_op(select, longint'(A), longint'(B), r, h, cc);
                    if (select == 3'd2) begin
                        p_out = r; p_hi = h; p_c = cc;
                        m_left = W; m_busy = 1;
                    end else begin
                        m_out = r; m_hi = 0; m_c = cc;
                        m_z = (r == 0); m_n = r[W-1];
                        m_done = 1;
                    end
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("m_busy",   longint'(busy),   longint'(m_busy));
                chk("m_done",   longint'(done),   longint'(m_done));
                chk("m_out",    longint'(out),    m_out);
                chk("m_out_hi", longint'(out_hi), m_hi);
                chk("m_z",      longint'(z_flag), longint'(m_z));
                chk("m_c",      longint'(c_flag), longint'(m_c));
                chk("m_n",      longint'(n_flag), longint'(m_n));
            end
        end
    end

    // Present one request for one cycle; returns at the next falling edge.
    task automatic issue(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; select = s; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issue a MUL, scramble operands, and check latency, busy span and result.
    task automatic mul_run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input longint e_lo, input longint e_hi, input bit e_z, input bit e_c);
        int c0, nb;
        c0 = cyc;
        issue(3'd2, a, b);
        A = W'($urandom); B = W'($urandom);
        nb = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) nb++;
            @(negedge clk);
        end
        chk({name, "_done"},    longint'(done), 1);
        chk({name, "_latency"}, longint'(cyc - c0), W + 1);
        chk({name, "_busy_n"},  longint'(nb), W);
        chk({name, "_busy0"},   longint'(busy), 0);
        chk({name, "_lo"},      longint'(out), e_lo);
        chk({name, "_hi"},      longint'(out_hi), e_hi);
        chk({name, "_z"},       longint'(z_flag), longint'(e_z));
        chk({name, "_c"},       longint'(c_flag), longint'(e_c));
    endtask

    logic [2:0]   t_sel [5] = '{3'd0, 3'd6, 3'd3, 3'd1, 3'd0};
    logic [W-1:0] t_a   [5] = '{16'h1234, 16'h8000, 16'h0000, 16'h0009, 16'h8000};
    logic [W-1:0] t_b   [5] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0009, 16'h8000};
    logic [W-1:0] t_out [5] = '{16'h1235, 16'h8001, 16'h0000, 16'h0000, 16'h0000};
    logic         t_c   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int c0, cnt;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; select = '0;
        repeat (3) @(negedge clk);
        chk("rst_out",  longint'(out), 0);
        chk("rst_hi",   longint'(out_hi), 0);
        chk("rst_flags", longint'({z_flag, c_flag, n_flag}), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(3'd0, 16'h0003, 16'hFFFD);
        chk("add_done", longint'(done), 1);
        chk("add_out",  longint'(out), 16'h0000);
        chk("add_zcn",  longint'({z_flag, c_flag, n_flag}), 3'b110);

        issue(3'd1, 16'h0005, 16'h0003);
        chk("sub_done", longint'(done), 1);
        chk("sub_out",  longint'(out), 16'hFFFE);
        chk("sub_hi",   longint'(out_hi), 0);
        chk("sub_zcn",  longint'({z_flag, c_flag, n_flag}), 3'b011);

        for (int i = 0; i < 5; i++) begin
            issue(t_sel[i], t_a[i], t_b[i]);
            chk("tbl_done", longint'(done), 1);
            chk("tbl_out",  longint'(out), longint'(t_out[i]));
            chk("tbl_c",    longint'(c_flag), longint'(t_c[i]));
        end

        mul_run("mul_a", 16'h0100, 16'h0300, 16'h0000, 16'h0003, 1'b1, 1'b1);
        mul_run("mul_ff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1);

        // MUL with an ADD request at iteration 5, then ADD on the done cycle.
        c0 = cyc;
        issue(3'd2, 16'h1234, 16'h0056);
        repeat (5) @(negedge clk);
        issue(3'd0, 16'h0001, 16'h0001);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        chk("ign_latency", longint'(cyc - c0), W + 1);
        chk("ign_lo", longint'(out), 16'h1D78);
        chk("ign_hi", longint'(out_hi), 16'h0006);
        issue(3'd0, 16'h0002, 16'h7FFF);
        chk("post_done", longint'(done), 1);
        chk("post_out",  longint'(out), 16'h8001);
        chk("post_hi",   longint'(out_hi), 0);
        chk("post_n",    longint'(n_flag), 1);
        @(negedge clk);
        chk("post_done_low", longint'(done), 0);

        // Back-to-back XOR, AND, PASS B.
        start = 1'b1; A = 16'h00FF; B = 16'h0F0F; select = 3'd7;
        @(negedge clk);
        chk("b2b_xor", longint'(out), 16'h0FF0);
        chk("b2b_xor_done", longint'(done), 1);
        select = 3'd5;
        @(negedge clk);
        chk("b2b_and", longint'(out), 16'h000F);
        chk("b2b_and_done", longint'(done), 1);
        select = 3'd4;
        @(negedge clk);
        chk("b2b_pasb", longint'(out), 16'h0F0F);
        chk("b2b_pasb_done", longint'(done), 1);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_done_low", longint'(done), 0);

        // Reset during MUL iteration 8.
        issue(3'd2, 16'hFFFF, 16'hFFFF);
        repeat (8) @(negedge clk);
        chk("abort_busy_before", longint'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_out",  longint'(out), 0);
        chk("abort_hi",   longint'(out_hi), 0);
        chk("abort_flags", longint'({z_flag, c_flag, n_flag}), 0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", longint'(cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
